mem_cmd_parser: RTL and testbench

- Bus-side front end that sits directly upstream of the flash memory engine in mem_top.
- Deserialises the 8-bit VALID_IN/DATA_IN byte stream into a header (opcode and source ID) plus a 24-bit address, then issues one transaction request to the SPI engine.
- For writes, streams the payload bytes to the engine; on completion, returns an acknowledgement carrying the requester's MODULE_SOURCE_ID.

---
 rtl/mem_cmd_parser.sv | 145 ++++++++++++++
 tb/tb_mem_cmd_parser.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_parser.sv
// Bus-side command parser in front of the flash SPI engine: header + 24-bit address in,
// one engine request out, write payload pass-through, source-ID ack. MEM_CMD_TIMEOUT_EN adds a WAIT_DONE watchdog.
module mem_cmd_parser #(
  parameter int DATA_BYTES     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        VALID_IN,
  input  logic [7:0]  DATA_IN,
  output logic        READY_IN,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [1:0]  req_op,
  output logic [23:0] req_addr,
  output logic [7:0]  req_len,
  output logic        wr_valid,
  output logic [7:0]  wr_data,
  input  logic        wr_ready,
  input  logic        eng_done,
  output logic        ACK_VALID,
  input  logic        ACK_READY,
  output logic [1:0]  MODULE_SOURCE_ID,
  output logic        err
);

  typedef enum logic [2:0] {HDR, ADDR, ISSUE, WDATA, WAIT_DONE, ACK} state_t;

  state_t      state;
  logic [1:0]  src;
  logic [1:0]  addr_cnt;
  logic [7:0]  byte_cnt;
  logic        done_seen;
  logic        xfer;

`ifdef MEM_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // Gating with rst_n keeps the bus stalled for the whole reset window.
  always_comb begin
    READY_IN = 1'b0;
    wr_valid = 1'b0;
    wr_data  = DATA_IN;
    if (rst_n) begin
      case (state)
        HDR, ADDR: READY_IN = 1'b1;
        WDATA: begin
          READY_IN = wr_ready;
          wr_valid = VALID_IN;
        end
        default: ;
      endcase
    end
  end

  assign xfer = VALID_IN && READY_IN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= HDR;
      src              <= '0;
      addr_cnt         <= '0;
      byte_cnt         <= '0;
      done_seen        <= 1'b0;
      req_valid        <= 1'b0;
      req_op           <= '0;
      req_addr         <= '0;
      req_len          <= '0;
      ACK_VALID        <= 1'b0;
      MODULE_SOURCE_ID <= '0;
      err              <= 1'b0;
`ifdef MEM_CMD_TIMEOUT_EN
      tmo_cnt          <= '0;
`endif
    end else begin
      err <= 1'b0;
      case (state)
        HDR: if (xfer) begin
          if (DATA_IN[7:6] == 2'b11) begin
            err <= 1'b1;
          end else begin
            req_op   <= DATA_IN[7:6];
            src      <= DATA_IN[5:4];
            req_len  <= (DATA_IN[7:6] == 2'b10) ? '0 : 8'(DATA_BYTES);
            addr_cnt <= '0;
            state    <= ADDR;
          end
        end
        ADDR: if (xfer) begin
          case (addr_cnt)
            2'd0:    req_addr[23:16] <= DATA_IN;
            2'd1:    req_addr[15:8]  <= DATA_IN;
            default: req_addr[7:0]   <= DATA_IN;
          endcase
          addr_cnt <= addr_cnt + 2'd1;
          if (addr_cnt == 2'd2) begin
            req_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: if (req_ready) begin
          req_valid <= 1'b0;
          byte_cnt  <= '0;
          if (eng_done) done_seen <= 1'b1;
          state <= (req_op == 2'b01) ? WDATA : WAIT_DONE;
        end
        WDATA: begin
          if (eng_done) done_seen <= 1'b1;
          if (xfer) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == 8'(DATA_BYTES - 1)) state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (eng_done || done_seen) begin
            done_seen        <= 1'b0;
            ACK_VALID        <= 1'b1;
            MODULE_SOURCE_ID <= src;
            state            <= ACK;
`ifdef MEM_CMD_TIMEOUT_EN
            tmo_cnt          <= '0;
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            err              <= 1'b1;
            done_seen        <= 1'b0;
            ACK_VALID        <= 1'b1;
            MODULE_SOURCE_ID <= src;
            state            <= ACK;
            tmo_cnt          <= '0;
          end else begin
            tmo_cnt          <= tmo_cnt + TW'(1);
`endif
          end
        end
        ACK: if (ACK_READY) begin
          ACK_VALID <= 1'b0;
          state     <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_parser.sv
// Directed self-checking bench for mem_cmd_parser; timeout scenario runs only with MEM_CMD_TIMEOUT_EN.
module tb_mem_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        VALID_IN = 1'b0;
  logic [7:0]  DATA_IN = '0;
  logic        READY_IN;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [7:0]  req_len;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready = 1'b0;
  logic        eng_done = 1'b0;
  logic        ACK_VALID;
  logic        ACK_READY = 1'b0;
  logic [1:0]  MODULE_SOURCE_ID;
  logic        err;

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  mem_cmd_parser #(.DATA_BYTES(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .VALID_IN(VALID_IN), .DATA_IN(DATA_IN), .READY_IN(READY_IN),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_len(req_len), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .eng_done(eng_done), .ACK_VALID(ACK_VALID), .ACK_READY(ACK_READY),
    .MODULE_SOURCE_ID(MODULE_SOURCE_ID), .err(err)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b);
    VALID_IN = 1'b1; DATA_IN = b; cyc(); VALID_IN = 1'b0;
  endtask

  task automatic issue_hs();
    req_ready = 1'b1; cyc(); req_ready = 1'b0;
  endtask

  task automatic done_pulse();
    eng_done = 1'b1; cyc(); eng_done = 1'b0;
  endtask

  task automatic ack_hs();
    ACK_READY = 1'b1; cyc(); ACK_READY = 1'b0;
  endtask

  task automatic test_reset();
    logic [41:0] outs;
    rst_n = 1'b0;
    repeat (2) cyc();
    outs = {READY_IN, req_valid, wr_valid, ACK_VALID, err, req_op, req_addr, req_len, MODULE_SOURCE_ID};
    vecs++; if (outs !== '0) begin miss++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst_n = 1'b1; #1;
    vecs++; if (READY_IN !== 1'b1) begin miss++; $display("FAIL reset_release_ready: got %b expected 1", READY_IN); end
  endtask

  task automatic test_read();
    send(8'h20); send(8'h12); send(8'h34); send(8'h56);
    for (int i = 0; i < 3; i++) begin
      vecs++; if ({req_valid, req_op, req_addr, req_len, READY_IN} !== {1'b1, 2'b00, 24'h123456, 8'd32, 1'b0}) begin
        miss++; $display("FAIL read_req[%0d]: got v=%b op=%b addr=%h len=%0d rdy=%b expected v=1 op=00 addr=123456 len=32 rdy=0",
                         i, req_valid, req_op, req_addr, req_len, READY_IN); end
      if (i < 2) cyc();
    end
    issue_hs();
    vecs++; if (req_valid !== 1'b0) begin miss++; $display("FAIL read_req_drop: got %b expected 0", req_valid); end
    for (int i = 0; i < 10; i++) begin
      vecs++; if (ACK_VALID !== 1'b0 || READY_IN !== 1'b0) begin miss++; $display("FAIL read_wait[%0d]: got ack=%b rdy=%b expected 0 0", i, ACK_VALID, READY_IN); end
      cyc();
    end
    done_pulse();
    for (int i = 0; i < 3; i++) begin
      vecs++; if ({ACK_VALID, MODULE_SOURCE_ID} !== {1'b1, 2'd2}) begin miss++; $display("FAIL read_ack_hold[%0d]: got v=%b id=%0d expected v=1 id=2", i, ACK_VALID, MODULE_SOURCE_ID); end
      if (i < 2) cyc();
    end
    ack_hs();
    vecs++; if ({ACK_VALID, READY_IN} !== 2'b01) begin miss++; $display("FAIL read_ack_release: got v=%b rdy=%b expected v=0 rdy=1", ACK_VALID, READY_IN); end
  endtask

  task automatic test_write();
    int sent = 0;
    int c = 0;
    send(8'h50); send(8'h00); send(8'h01); send(8'h00);
    vecs++; if ({req_valid, req_op, req_addr, req_len} !== {1'b1, 2'b01, 24'h000100, 8'd32}) begin
      miss++; $display("FAIL write_req: got v=%b op=%b addr=%h len=%0d expected v=1 op=01 addr=000100 len=32", req_valid, req_op, req_addr, req_len); end
    issue_hs();
    while (sent < 32 && c < 200) begin
      wr_ready = ((c % 2) == 0);
      VALID_IN = 1'b1; DATA_IN = 8'(sent);
      #1;
      vecs++; if ({READY_IN, wr_valid, wr_data} !== {wr_ready, 1'b1, 8'(sent)}) begin
        miss++; $display("FAIL write_byte[%0d]: got rdy=%b wv=%b wd=%h expected rdy=%b wv=1 wd=%h", sent, READY_IN, wr_valid, wr_data, wr_ready, 8'(sent)); end
      cyc();
      if (wr_ready) sent++;
      c++;
    end
    vecs++; if (sent !== 32) begin miss++; $display("FAIL write_count: got %0d expected 32", sent); end
    VALID_IN = 1'b0; wr_ready = 1'b1; #1;
    vecs++; if ({READY_IN, wr_valid, ACK_VALID} !== 3'b000) begin miss++; $display("FAIL write_wait: got rdy=%b wv=%b ack=%b expected 000", READY_IN, wr_valid, ACK_VALID); end
    wr_ready = 1'b0;
    done_pulse();
    vecs++; if ({ACK_VALID, MODULE_SOURCE_ID} !== {1'b1, 2'd1}) begin miss++; $display("FAIL write_ack: got v=%b id=%0d expected v=1 id=1", ACK_VALID, MODULE_SOURCE_ID); end
    ack_hs();
  endtask

  task automatic test_erase_reserved();
    send(8'hB0); send(8'hAB); send(8'hC0); send(8'h00);
    VALID_IN = 1'b1; DATA_IN = 8'hEE; wr_ready = 1'b1; #1;
    vecs++; if ({req_valid, req_op, req_addr, req_len, wr_valid, READY_IN} !== {1'b1, 2'b10, 24'hABC000, 8'd0, 1'b0, 1'b0}) begin
      miss++; $display("FAIL erase_req: got v=%b op=%b addr=%h len=%0d wv=%b rdy=%b expected v=1 op=10 addr=abc000 len=0 wv=0 rdy=0",
                       req_valid, req_op, req_addr, req_len, wr_valid, READY_IN); end
    VALID_IN = 1'b0; wr_ready = 1'b0;
    issue_hs();
    cyc(); cyc();
    vecs++; if ({ACK_VALID, wr_valid} !== 2'b00) begin miss++; $display("FAIL erase_wait: got ack=%b wv=%b expected 00", ACK_VALID, wr_valid); end
    done_pulse();
    vecs++; if ({ACK_VALID, MODULE_SOURCE_ID} !== {1'b1, 2'd3}) begin miss++; $display("FAIL erase_ack: got v=%b id=%0d expected v=1 id=3", ACK_VALID, MODULE_SOURCE_ID); end
    ack_hs();
    send(8'hC0);
    vecs++; if ({err, req_valid, READY_IN} !== 3'b101) begin miss++; $display("FAIL reserved_err: got err=%b rv=%b rdy=%b expected 1 0 1", err, req_valid, READY_IN); end
    send(8'h20);
    vecs++; if (err !== 1'b0) begin miss++; $display("FAIL reserved_err_width: got %b expected 0", err); end
    send(8'h00); send(8'h00); send(8'h40);
    vecs++; if ({req_valid, req_op, req_addr, req_len} !== {1'b1, 2'b00, 24'h000040, 8'd32}) begin
      miss++; $display("FAIL reserved_next_hdr: got v=%b op=%b addr=%h len=%0d expected v=1 op=00 addr=000040 len=32", req_valid, req_op, req_addr, req_len); end
    issue_hs();
    done_pulse();
    vecs++; if ({ACK_VALID, MODULE_SOURCE_ID} !== {1'b1, 2'd2}) begin miss++; $display("FAIL reserved_next_ack: got v=%b id=%0d expected v=1 id=2", ACK_VALID, MODULE_SOURCE_ID); end
    ack_hs();
  endtask

  task automatic test_done_coincident();
    int acks = 0;
    send(8'h70); send(8'h00); send(8'h00); send(8'h00);
    issue_hs();
    wr_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      VALID_IN = 1'b1; DATA_IN = 8'(8'hA0 + i); eng_done = (i == 31);
      cyc();
    end
    VALID_IN = 1'b0; eng_done = 1'b0; wr_ready = 1'b0;
    vecs++; if (ACK_VALID !== 1'b0) begin miss++; $display("FAIL coincident_early: got %b expected 0", ACK_VALID); end
    cyc();
    vecs++; if ({ACK_VALID, MODULE_SOURCE_ID} !== {1'b1, 2'd3}) begin miss++; $display("FAIL coincident_ack: got v=%b id=%0d expected v=1 id=3", ACK_VALID, MODULE_SOURCE_ID); end
    ack_hs();
    for (int i = 0; i < 6; i++) begin
      if (ACK_VALID) acks++;
      cyc();
    end
    vecs++; if (acks !== 0) begin miss++; $display("FAIL coincident_single_ack: got %0d extra acks expected 0", acks); end
  endtask

  task automatic test_done_seen();
    eng_done = 1'b1; cyc(); eng_done = 1'b0;
    send(8'h30); send(8'h00); send(8'h00); send(8'h08);
    done_pulse();
    issue_hs();
    for (int i = 0; i < 3; i++) begin
      vecs++; if (ACK_VALID !== 1'b0) begin miss++; $display("FAIL stale_done[%0d]: got %b expected 0", i, ACK_VALID); end
      cyc();
    end
    done_pulse();
    vecs++; if ({ACK_VALID, MODULE_SOURCE_ID} !== {1'b1, 2'd3}) begin miss++; $display("FAIL stale_done_ack: got v=%b id=%0d expected v=1 id=3", ACK_VALID, MODULE_SOURCE_ID); end
    ack_hs();
    send(8'h10); send(8'h00); send(8'h00); send(8'h10);
    req_ready = 1'b1; eng_done = 1'b1; cyc(); req_ready = 1'b0; eng_done = 1'b0;
    vecs++; if (ACK_VALID !== 1'b0) begin miss++; $display("FAIL hs_done_early: got %b expected 0", ACK_VALID); end
    cyc();
    vecs++; if ({ACK_VALID, MODULE_SOURCE_ID} !== {1'b1, 2'd1}) begin miss++; $display("FAIL hs_done_ack: got v=%b id=%0d expected v=1 id=1", ACK_VALID, MODULE_SOURCE_ID); end
    ack_hs();
  endtask

  task automatic test_reset_mid_write();
    logic [41:0] outs;
    int acks = 0;
    send(8'h50); send(8'h00); send(8'h02); send(8'h00);
    issue_hs();
    wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(i));
    VALID_IN = 1'b1; rst_n = 1'b0; #1;
    outs = {READY_IN, req_valid, wr_valid, ACK_VALID, err, req_op, req_addr, req_len, MODULE_SOURCE_ID};
    vecs++; if (outs !== '0) begin miss++; $display("FAIL midreset_outputs: got %h expected 0", outs); end
    VALID_IN = 1'b0; wr_ready = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1; #1;
    vecs++; if (READY_IN !== 1'b1) begin miss++; $display("FAIL midreset_ready: got %b expected 1", READY_IN); end
    for (int i = 0; i < 5; i++) begin
      if (ACK_VALID) acks++;
      cyc();
    end
    vecs++; if (acks !== 0) begin miss++; $display("FAIL midreset_no_ack: got %0d acks expected 0", acks); end
    send(8'h10); send(8'h0A); send(8'h0B); send(8'h0C);
    vecs++; if ({req_valid, req_op, req_addr, req_len} !== {1'b1, 2'b00, 24'h0A0B0C, 8'd32}) begin
      miss++; $display("FAIL midreset_read_req: got v=%b op=%b addr=%h len=%0d expected v=1 op=00 addr=0a0b0c len=32", req_valid, req_op, req_addr, req_len); end
    issue_hs();
    done_pulse();
    vecs++; if ({ACK_VALID, MODULE_SOURCE_ID} !== {1'b1, 2'd1}) begin miss++; $display("FAIL midreset_read_ack: got v=%b id=%0d expected v=1 id=1", ACK_VALID, MODULE_SOURCE_ID); end
    ack_hs();
  endtask

`ifdef MEM_CMD_TIMEOUT_EN
  task automatic test_timeout();
    send(8'h20); send(8'h00); send(8'h00); send(8'h01);
    issue_hs();
    for (int i = 0; i < 15; i++) begin
      cyc();
      vecs++; if ({err, ACK_VALID} !== 2'b00) begin miss++; $display("FAIL timeout_early[%0d]: got err=%b ack=%b expected 00", i, err, ACK_VALID); end
    end
    cyc();
    vecs++; if ({err, ACK_VALID, MODULE_SOURCE_ID} !== {1'b1, 1'b1, 2'd2}) begin
      miss++; $display("FAIL timeout_fire: got err=%b ack=%b id=%0d expected err=1 ack=1 id=2", err, ACK_VALID, MODULE_SOURCE_ID); end
    cyc();
    vecs++; if ({err, ACK_VALID} !== 2'b01) begin miss++; $display("FAIL timeout_err_width: got err=%b ack=%b expected err=0 ack=1", err, ACK_VALID); end
    ack_hs();
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_read();
    test_write();
    test_erase_reserved();
    test_done_coincident();
    test_done_seen();
    test_reset_mid_write();
`ifdef MEM_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
